// File: rtl/prog_loader.sv
// Boot-time program loader: takes a length-prefixed, XOR-checksummed byte stream and writes
// 32-bit words into instruction memory from address 0. The CPU stays held until the image verifies.
module prog_loader #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    // Word counter must hold any 16-bit length minus one as well as a full address.
    localparam int unsigned CW       = (ADDR_W > 16) ? ADDR_W : 16;
    localparam logic [32:0] CAPACITY = 33'd1 << ADDR_W;

    typedef enum logic [2:0] {
        StIdle,
        StLen0,
        StLen1,
        StData,
        StCsum,
        StDone,
        StErr
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [15:0]       len_q, len_d;
    logic [7:0]        acc_q, acc_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [CW-1:0]     word_idx_q, word_idx_d;
    logic [23:0]       wbuf_q, wbuf_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic        accept;
    logic [15:0] n_full;
    logic        last_word;

    always_comb begin
        in_ready = (state_q == StLen0) || (state_q == StLen1) ||
                   (state_q == StData) || (state_q == StCsum);
        cpu_hold = (state_q != StDone);
        done     = (state_q == StDone);
        error    = (state_q == StErr);
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;

    assign accept    = in_valid && in_ready;
    assign n_full    = {in_data, len_lo_q};
    assign last_word = (word_idx_q == (CW'(len_q) - CW'(1)));

    always_comb begin
        state_d    = state_q;
        len_lo_d   = len_lo_q;
        len_d      = len_q;
        acc_d      = acc_q;
        byte_idx_d = byte_idx_q;
        word_idx_d = word_idx_q;
        wbuf_d     = wbuf_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;

        case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d    = StLen0;
                    acc_d      = 8'h00;
                    byte_idx_d = 2'd0;
                    word_idx_d = '0;
                end
            end
            StLen0: begin
                if (accept) begin
                    len_lo_d = in_data;
                    state_d  = StLen1;
                end
            end
            StLen1: begin
                if (accept) begin
                    len_d = n_full;
                    if ({17'd0, n_full} > CAPACITY) begin
                        state_d = StErr;
                    end else if (n_full == 16'd0) begin
                        state_d = StCsum;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    acc_d      = acc_q ^ in_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    unique case (byte_idx_q)
                        2'd0: wbuf_d[7:0]   = in_data;
                        2'd1: wbuf_d[15:8]  = in_data;
                        2'd2: wbuf_d[23:16] = in_data;
                        2'd3: begin
                            we_d       = 1'b1;
                            addr_d     = word_idx_q[ADDR_W-1:0];
                            wdata_d    = {in_data, wbuf_q};
                            word_idx_d = word_idx_q + CW'(1);
                            if (last_word) begin
                                state_d = StCsum;
                            end
                        end
                    endcase
                end
            end
            StCsum: begin
                if (accept) begin
                    state_d = (in_data == acc_q) ? StDone : StErr;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            len_lo_q   <= 8'h00;
            len_q      <= 16'h0000;
            acc_q      <= 8'h00;
            byte_idx_q <= 2'd0;
            word_idx_q <= '0;
            wbuf_q     <= 24'h000000;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            len_lo_q   <= len_lo_d;
            len_q      <= len_d;
            acc_q      <= acc_d;
            byte_idx_q <= byte_idx_d;
            word_idx_q <= word_idx_d;
            wbuf_q     <= wbuf_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: normal, gapped, bad-checksum, zero-length, overflow,
// full-capacity, reset-abandon and ignored-start scenarios.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [7:0]  bytes_q[$];
    logic [7:0]  wa[$];
    logic [31:0] wd[$];
    logic [31:0] exp_w[3] = '{32'h00a00293, 32'h00a00313, 32'h0000006f};

    prog_loader #(.ADDR_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold),
        .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // One entry per cycle with the write strobe high.
    always @(negedge clk) begin
        if (imem_we) begin
            wa.push_back(imem_addr);
            wd.push_back(imem_wdata);
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        ok = 0;
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (in_ready) ok = 1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_byte_timeout: in_ready=%0b required 1", in_ready);
        end
    endtask

    task automatic send_range(input int lo, input int hi, input int maxgap);
        for (int i = lo; i <= hi; i++) begin
            send_byte(bytes_q[i], (maxgap == 0) ? 0 : int'($urandom_range(maxgap, 0)));
        end
    endtask

    task automatic load_std(input logic [7:0] csum);
        bytes_q = '{8'h03, 8'h00, 8'h93, 8'h02, 8'ha0, 8'h00, 8'h13, 8'h03,
                    8'ha0, 8'h00, 8'h6f, 8'h00, 8'h00, 8'h00, csum};
    endtask

    task automatic test_reset();
        #2;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b exp 0", in_ready); end
        checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b exp 0", imem_we); end
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL reset_hold: got %b exp 1", cpu_hold); end
        checks++; if ({done, error} !== 2'b00) begin errors++; $display("FAIL reset_done_err: got %b exp 00", {done, error}); end
        checks++; if ({imem_addr, imem_wdata} !== 40'd0) begin errors++; $display("FAIL reset_addr_data: got %h exp 0", {imem_addr, imem_wdata}); end
        @(posedge clk); #1;
        rst = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL idle_in_ready: got %b exp 0", in_ready); end
        in_valid = 1'b0;
    endtask

    task automatic test_normal();
        int t0;
        wa.delete(); wd.delete();
        load_std(8'hee);
        pulse_start();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL start_ready: got %b exp 1", in_ready); end
        t0 = cyc;
        send_range(0, 14, 0);
        checks++; if (cyc - t0 != 15) begin errors++; $display("FAIL b2b_cycles: got %0d exp 15", cyc - t0); end
        checks++; if (wa.size() != 3) begin errors++; $display("FAIL normal_nwrites: got %0d exp 3", wa.size()); end
        for (int i = 0; i < 3 && i < wa.size(); i++) begin
            checks++;
            if (wa[i] !== 8'(i) || wd[i] !== exp_w[i]) begin
                errors++; $display("FAIL normal_write%0d: got %h@%h exp %h@%h", i, wd[i], wa[i], exp_w[i], i);
            end
        end
        checks++; if ({done, cpu_hold, in_ready, error} !== 4'b1000) begin errors++; $display("FAIL normal_final: got %b exp 1000", {done, cpu_hold, in_ready, error}); end
    endtask

    task automatic test_gaps();
        wa.delete(); wd.delete();
        load_std(8'hee);
        pulse_start();
        send_range(0, 14, 5);
        checks++; if (wa.size() != 3) begin errors++; $display("FAIL gaps_nwrites: got %0d exp 3", wa.size()); end
        for (int i = 0; i < 3 && i < wa.size(); i++) begin
            checks++;
            if (wa[i] !== 8'(i) || wd[i] !== exp_w[i]) begin
                errors++; $display("FAIL gaps_write%0d: got %h@%h exp %h@%h", i, wd[i], wa[i], exp_w[i], i);
            end
        end
        checks++; if ({done, cpu_hold, in_ready, error} !== 4'b1000) begin errors++; $display("FAIL gaps_final: got %b exp 1000", {done, cpu_hold, in_ready, error}); end
    endtask

    task automatic test_bad_csum();
        wa.delete(); wd.delete();
        load_std(8'hef);
        pulse_start();
        send_range(0, 14, 0);
        checks++; if (wa.size() != 3) begin errors++; $display("FAIL bad_nwrites: got %0d exp 3", wa.size()); end
        checks++; if (wa.size() == 3 && wd[2] !== 32'h0000006f) begin errors++; $display("FAIL bad_last_word: got %h exp 0000006f", wd[2]); end
        checks++; if ({error, done, cpu_hold, in_ready} !== 4'b1010) begin errors++; $display("FAIL bad_final: got %b exp 1010", {error, done, cpu_hold, in_ready}); end
    endtask

    task automatic test_zero_len();
        wa.delete(); wd.delete();
        bytes_q = '{8'h00, 8'h00, 8'h00};
        pulse_start();
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL start_clears_error: got %b exp 0", error); end
        send_range(0, 2, 0);
        checks++; if ({done, error, wa.size() == 0} !== 3'b101) begin errors++; $display("FAIL zero_ok: got done/err/nowrite %b exp 101", {done, error, wa.size() == 0}); end
        bytes_q = '{8'h00, 8'h00, 8'h01};
        pulse_start();
        send_range(0, 2, 0);
        checks++; if ({done, error, wa.size() == 0} !== 3'b011) begin errors++; $display("FAIL zero_bad: got done/err/nowrite %b exp 011", {done, error, wa.size() == 0}); end
    endtask

    task automatic test_overflow();
        wa.delete(); wd.delete();
        bytes_q = '{8'h01, 8'h01};
        pulse_start();
        send_range(0, 1, 0);
        checks++; if ({error, in_ready, cpu_hold} !== 3'b101) begin errors++; $display("FAIL ovf_state: got %b exp 101", {error, in_ready, cpu_hold}); end
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (wa.size() != 0) begin errors++; $display("FAIL ovf_nwrites: got %0d exp 0", wa.size()); end
    endtask

    task automatic test_n256();
        wa.delete(); wd.delete();
        bytes_q = '{8'h00, 8'h01};
        for (int j = 0; j < 1024; j++) bytes_q.push_back(8'(j));
        bytes_q.push_back(8'h00);  // every byte value appears four times
        pulse_start();
        send_range(0, 1026, 0);
        checks++; if (wa.size() != 256) begin errors++; $display("FAIL n256_nwrites: got %0d exp 256", wa.size()); end
        if (wa.size() == 256) begin
            checks++; if (wa[0] !== 8'h00 || wd[0] !== 32'h03020100) begin errors++; $display("FAIL n256_first: got %h@%h exp 03020100@00", wd[0], wa[0]); end
            checks++; if (wa[255] !== 8'hff || wd[255] !== 32'hfffefdfc) begin errors++; $display("FAIL n256_last: got %h@%h exp fffefdfc@ff", wd[255], wa[255]); end
        end
        checks++; if ({done, error} !== 2'b10) begin errors++; $display("FAIL n256_done: got %b exp 10", {done, error}); end
    endtask

    task automatic test_reset_midload();
        load_std(8'hee);
        pulse_start();
        send_range(0, 7, 0);
        rst = 1'b0;
        #1;
        checks++; if ({in_ready, imem_we, done, error, cpu_hold} !== 5'b00001) begin errors++; $display("FAIL rst_mid_ctl: got %b exp 00001", {in_ready, imem_we, done, error, cpu_hold}); end
        checks++; if ({imem_addr, imem_wdata} !== 40'd0) begin errors++; $display("FAIL rst_mid_data: got %h exp 0", {imem_addr, imem_wdata}); end
        @(posedge clk); #1;
        rst = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h03;
        repeat (2) begin @(posedge clk); #1; end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_idle: got %b exp 0", in_ready); end
        in_valid = 1'b0;
        wa.delete(); wd.delete();
        pulse_start();
        send_range(0, 14, 0);
        checks++; if ({done, error, wa.size() == 3} !== 3'b101) begin errors++; $display("FAIL rst_rearm: got done/err/3writes %b exp 101", {done, error, wa.size() == 3}); end
    endtask

    task automatic test_start_mid_data();
        wa.delete(); wd.delete();
        load_std(8'hee);
        pulse_start();
        send_range(0, 3, 0);
        pulse_start();
        send_range(4, 14, 0);
        checks++; if (wa.size() != 3) begin errors++; $display("FAIL middata_nwrites: got %0d exp 3", wa.size()); end
        for (int i = 0; i < 3 && i < wa.size(); i++) begin
            checks++;
            if (wa[i] !== 8'(i) || wd[i] !== exp_w[i]) begin
                errors++; $display("FAIL middata_write%0d: got %h@%h exp %h@%h", i, wd[i], wa[i], exp_w[i], i);
            end
        end
        checks++; if ({done, error} !== 2'b10) begin errors++; $display("FAIL middata_done: got %b exp 10", {done, error}); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_gaps();
        test_bad_csum();
        test_zero_len();
        test_overflow();
        test_n256();
        test_reset_midload();
        test_start_mid_data();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader between a byte-stream host link and the CPU's instruction memory write port. Receives a length-prefixed, checksummed little-endian image, assembles 32-bit instruction words and writes them to consecutive word addresses from 0. Holds the CPU in reset until the image is complete and verified. Replaces direct memory preloading for branch/ALU programs on hardware and in system-level benches.

## Interface
- `ADDR_W`, default 8: instruction memory word-address width; capacity is 2**ADDR_W words.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle arm request; honoured only in IDLE, DONE or ERR.
- `in_valid`  in  1  host byte valid.
- `in_data`  in  8  host byte.
- `in_ready`  out  1  loader accepts byte; a transfer occurs when `in_valid && in_ready` at a rising edge.
- `imem_we`  out  1  instruction memory write strobe, one cycle per word.
- `imem_addr`  out  ADDR_W  word address.
- `imem_wdata`  out  32  instruction word.
- `cpu_hold`  out  1  high keeps the CPU in reset.
- `done`  out  1  image loaded and checksum matched.
- `error`  out  1  sticky load failure.

## Operation
- Stream format: LEN_LO, LEN_HI (16-bit word count N), then 4·N payload bytes, each word LS byte first, then one CSUM byte equal to the XOR of all payload bytes.
- States: IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR.
  - IDLE: `start` moves to LEN0 and clears the checksum accumulator, byte and word counters.
  - LEN0: accepting a byte stores LEN_LO, then moves to LEN1.
  - LEN1: accepting a byte forms N.
    - If N > 2**ADDR_W, go to ERR.
    - If N == 0, go to CSUM.
    - Otherwise go to DATA.
  - DATA: each accepted byte is shifted into bits [8·k+7:8·k] (k = byte index 0..3) and XORed into the accumulator.
    - On the 4th byte, write the word to address `word_idx` and increment `word_idx`.
    - After the word with `word_idx` == N−1, go to CSUM.
  - CSUM: on an accepted byte, go to DONE if it equals the accumulator, otherwise to ERR.
  - DONE and ERR: hold until `start`, which re-arms exactly as from IDLE.
- `in_ready` is 1 in LEN0, LEN1, DATA and CSUM; it is 0 in IDLE, DONE and ERR.
- `cpu_hold` is 1 in every state except DONE.
- `done` is 1 only in DONE.
- `error` is 1 in ERR and cleared by `start`.
- Words written before a checksum failure stay in memory, and the CPU stays held.
- `start` in LEN0, LEN1, DATA or CSUM is ignored.
- `in_valid` gaps of any length are allowed; no timeout.
- Bytes presented while `in_ready` = 0 are not consumed.

## Timing
- Reset (`rst` = 0), taking effect immediately:
  - state goes to IDLE;
  - `in_ready`, `imem_we`, `done` and `error` go to 0;
  - `imem_addr` and `imem_wdata` go to 0;
  - `cpu_hold` goes to 1.
- Reset asserted mid-load abandons the load. The partial memory contents are left as they are.
- All outputs are registered or decoded directly from the state register; there is no combinational path from `in_*` to any output.
- Maximum throughput is one byte per cycle, with `in_ready` held high continuously through DATA.
- Write latency: the 4th byte of a word is accepted at edge E. `imem_we` = 1, with `imem_addr`/`imem_wdata` valid, for exactly the cycle between E and E+1.
- The state transition out of LEN1, DATA or CSUM takes effect at the edge that accepts the triggering byte.
- When the CSUM byte is accepted at edge E:
  - `done` rises at E;
  - `cpu_hold` falls at E;
  - `in_ready` falls at E.
- From `start` sampled in IDLE at edge S, `in_ready` = 1 from S onward.

## Test plan
- Normal load, N = 3: send `03 00 93 02 a0 00 13 03 a0 00 6f 00 00 00 ee`. Required:
  - three `imem_we` pulses writing 0x00a00293, 0x00a00313, 0x0000006f to addresses 0, 1, 2;
  - then `done` = 1 and `cpu_hold` = 0.
  - Back-to-back bytes take 15 accepted cycles.
- Same stream with random 0–5 cycle `in_valid` gaps: identical writes and identical final state.
- Bad checksum: same stream with CSUM = 0xef. Required:
  - all three writes still occur;
  - then `error` = 1, `done` = 0, `cpu_hold` = 1, `in_ready` = 0.
- Zero length: `00 00 00` gives no writes and `done` = 1. `00 00 01` gives `error` = 1.
- Overflow with ADDR_W = 8:
  - `01 01` (N = 257) goes to ERR right after the LEN_HI byte, with no writes.
  - N = 256 is accepted, and its last write goes to address 255.
- Reset and re-arm:
  - Assert `rst` after 6 payload bytes: outputs go immediately to their reset values, and state is IDLE.
  - After a fresh `start` and the full valid stream, expect `done` = 1.
  - `start` pulsed mid-DATA has no effect.
